// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if : request/response bundle between pipeline control and PC sequencer
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if;
  logic        stall;
  logic        ex_redirect;
  logic [15:0] ex_target;
  logic        id_jump;
  logic        id_call;
  logic        id_ret;
  logic [15:0] id_target;
  logic [15:0] id_pc;
  logic [15:0] PC;
  logic        flush_IF;
  logic        flush_ID;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  modport slave (
    input  stall, ex_redirect, ex_target, id_jump, id_call, id_ret, id_target, id_pc,
    output PC, flush_IF, flush_ID, ras_empty, ras_full, ras_err
  );

  modport master (
    output stall, ex_redirect, ex_target, id_jump, id_call, id_ret, id_target, id_pc,
    input  PC, flush_IF, flush_ID, ras_empty, ras_full, ras_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer : fetch-address sequencer with branch/jump/return redirect and RAS
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
  parameter int RAS_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          first,
  pc_sequencer_if.slave bus
);

  localparam int SPW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNTW = SPW + 1;

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_pc;
  logic [15:0]     w_pc_nxt;
  logic            r_flush_if;
  logic            r_flush_id;
  logic            w_flush_if_nxt;
  logic            w_flush_id_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_err_set;
  logic            r_err;
  logic [15:0]     r_ras [RAS_DEPTH];
  logic [SPW-1:0]  r_sp;
  logic [CNTW-1:0] r_cnt;
  logic            w_empty;
  logic            w_full;
  logic [15:0]     w_top;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNTW'(RAS_DEPTH));
  assign w_top   = r_ras[r_sp - SPW'(1)];

  always_comb begin
    w_state_nxt    = S_RUN;
    w_pc_nxt       = r_pc + 16'd1;
    w_flush_if_nxt = 1'b0;
    w_flush_id_nxt = 1'b0;
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_err_set      = 1'b0;
    case (r_state)
      // Leaving reset fetches sequentially; ID/EX contents are still bubbles.
      S_RESET: ;
      default: begin
        if (bus.ex_redirect) begin
          w_pc_nxt       = bus.ex_target;
          w_state_nxt    = S_REDIRECT;
          w_flush_if_nxt = 1'b1;
          w_flush_id_nxt = 1'b1;
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (bus.id_ret) begin
          if (!w_empty) begin
            w_pc_nxt       = w_top;
            w_pop          = 1'b1;
            w_flush_if_nxt = 1'b1;
            w_state_nxt    = S_REDIRECT;
          end else begin
            w_err_set = 1'b1;
          end
        end else if (bus.id_jump) begin
          w_pc_nxt       = bus.id_target;
          w_flush_if_nxt = 1'b1;
          w_state_nxt    = S_REDIRECT;
          if (bus.id_call) begin
            w_push    = 1'b1;
            w_err_set = w_full;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (first) begin
      r_state    <= S_RESET;
      r_pc       <= 16'h0000;
      r_flush_if <= 1'b1;
      r_flush_id <= 1'b1;
      r_sp       <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_flush_if <= w_flush_if_nxt;
      r_flush_id <= w_flush_id_nxt;
      if (w_err_set) r_err <= 1'b1;
      // A push when full overwrites the oldest slot, which is the one at r_sp.
      if (w_push) begin
        r_sp <= r_sp + SPW'(1);
        if (!w_full) r_cnt <= r_cnt + CNTW'(1);
      end else if (w_pop) begin
        r_sp  <= r_sp - SPW'(1);
        r_cnt <= r_cnt - CNTW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!first && w_push) r_ras[r_sp] <= bus.id_pc + 16'd1;
  end

  assign bus.PC        = r_pc;
  assign bus.flush_IF  = r_flush_if;
  assign bus.flush_ID  = r_flush_id;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = w_full;
  assign bus.ras_err   = r_err;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RAS_DEPTH, default 4, SHALL set the return-address-stack entry count (power of two, 2..16).
REQ-002 CLK  input  1  SHALL be the single clock; all state SHALL update on posedge CLK only.
REQ-003 first  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 stall  input  1  SHALL request that PC be held (load-use hazard).
REQ-005 ex_redirect  input  1  SHALL flag a taken branch resolved in EX.
REQ-006 ex_target  input  16  SHALL give the EX branch target.
REQ-007 id_jump  input  1  SHALL flag an unconditional jump decoded in ID.
REQ-008 id_call  input  1  SHALL qualify id_jump as a call (push return address).
REQ-009 id_ret  input  1  SHALL flag a return decoded in ID.
REQ-010 id_target  input  16  SHALL give the ID jump/call target.
REQ-011 id_pc  input  16  SHALL give the PC of the instruction in ID.
REQ-012 PC  output  16  SHALL be the registered fetch address.
REQ-013 flush_IF  output  1  SHALL tell IF/ID to insert a bubble.
REQ-014 flush_ID  output  1  SHALL tell ID/EX to insert a bubble.
REQ-015 ras_empty, ras_full  output  1 each  SHALL reflect RAS occupancy (0 / RAS_DEPTH entries).
REQ-016 ras_err  output  1  SHALL be a sticky RAS overflow/underflow flag.

Function
REQ-017 FSM states: RESET, RUN, REDIRECT; state, PC, flush_IF, flush_ID all registered.
REQ-018 RESET: entered while first=1; exits to RUN at the first edge with first=0; flush_IF=flush_ID=1 while in RESET.
REQ-019 Next-PC priority in RUN/REDIRECT (highest first): ex_redirect, stall, id_ret, id_jump, sequential.
REQ-020 ex_redirect=1: PC<=ex_target; next state REDIRECT with flush_IF=flush_ID=1 for exactly one cycle; overrides stall.
REQ-021 ex_redirect=1 together with id_jump/id_ret: ID action discarded, including RAS push/pop.
REQ-022 stall=1 (no ex_redirect): PC held, RAS unchanged, id_jump/id_ret ignored (ID instruction re-presented next cycle), flushes 0.
REQ-023 id_jump=1, id_call=0: PC<=id_target; flush_IF=1, flush_ID=0 next cycle; state REDIRECT.
REQ-024 id_jump=1, id_call=1: as REQ-023, plus push id_pc+1 (mod 2^16) onto the RAS.
REQ-025 id_ret=1, RAS non-empty: PC<=top entry, pop; flush_IF=1 next cycle.
REQ-026 id_ret=1, RAS empty: PC<=PC+1, no flush, ras_err<=1, occupancy stays 0.
REQ-027 Push when full: circular overwrite of oldest entry; occupancy stays RAS_DEPTH; ras_err<=1.
REQ-028 id_ret and id_jump both 1: id_ret wins; id_jump ignored.
REQ-029 Sequential: PC<=PC+1 (word-addressed), 0xFFFF wraps to 0x0000 with no flag.
REQ-030 REDIRECT returns to RUN after one cycle unless a new redirect occurs; REDIRECT accepts all inputs as RUN does.
REQ-031 Flush outputs SHALL be 0 in any cycle not caused by REQ-018/020/023/024/025.

Reset
REQ-032 first=1 at any edge SHALL set PC=0x0000, state RESET, RAS occupancy 0, ras_empty=1, ras_full=0, ras_err=0, flush_IF=flush_ID=1, overriding all other inputs, including mid-redirect and mid-stall.
REQ-033 RAS entry contents need not be cleared by reset.

Verification
REQ-034 first=1 two cycles then 0, no requests -> PC 0,0,1,2,3; flushes 1,1 then 0.
REQ-035 PC=0x0010, stall=1 and ex_redirect=1 (ex_target=0x0200) same cycle -> PC=0x0200, flush_IF=flush_ID=1 one cycle, then PC=0x0201.
REQ-036 id_call at id_pc=0x0040, id_target=0x0100; later id_ret -> PC=0x0100, then on ret PC=0x0041, ras_empty=1, ras_err=0.
REQ-037 Five calls (RAS_DEPTH=4, id_pc=0x10,0x20,0x30,0x40,0x50) then five rets -> returns 0x51,0x41,0x31,0x21, fifth ret PC+1; ras_err=1 after fifth call.
REQ-038 PC=0xFFFF sequential -> 0x0000; id_jump with ex_redirect same cycle -> PC=ex_target, RAS unchanged.
REQ-039 first=1 asserted during REDIRECT with RAS holding 2 entries -> PC=0, ras_empty=1, ras_err=0 next cycle.
